instr_decode_ctrl: RTL and testbench
====================================

// Module: instr_decode_ctrl
// PURPOSE
//  Multi-cycle control/decode stage directly downstream of instructMem. Latches the
//  8-bit instruction (opcode/rt/rs/aux) and sequences FETCH->DECODE->EXEC->WB.
//  Drives register-file, ALU and program_counter controls.
//  Owns PC update (increment or relative branch), halt, and a retired-instruction counter.
// PARAMETERS
//  PC_W   8   program counter / instruction memory address width
//  RET_W  16  retired-instruction counter width (wraps)
// PORTS
//  sysclk      in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  opcode      in   3      from instructMem, decoded per table below
//  rt          in   1      dest / first source register index
//  rs          in   1      second source / branch-test register index
//  aux         in   3      immediate (LI zero-ext, BEQZ signed offset)
//  pc          in   PC_W   current PC (also instructMem addr)
//  rs_zero     in   1      register file: value of reg[rs_addr]==0
//  step        in   1      single-step request (present only with CTRL_SINGLE_STEP_EN)
//  rt_addr     out  1      register file read port A / write address = IR.rt
//  rs_addr     out  1      register file read port B = IR.rs
//  alu_op      out  2      00 ADD, 01 SUB, 10 AND, 11 OR
//  alu_src_imm out  1      1: ALU B operand = imm (LI)
//  imm         out  8      zero-extended IR.aux
//  rf_we       out  1      register-file write strobe (WB only)
//  pc_we       out  1      program_counter load strobe
//  pc_next     out  PC_W   value loaded into PC when pc_we=1
//  halted      out  1      1 while in HALT
//  retired     out  RET_W  instructions completed since reset
// BEHAVIOUR
//  Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR (rt<=rt op rs); 100 LI (rt<=aux);
//   101 BEQZ (if reg[rs]==0 PC<=PC+sext(aux) else PC+1); 110 NOP; 111 HALT.
//  States (2-bit reg, async reset to FETCH): FETCH, DECODE, EXEC, WB, plus HALT (3-bit ok).
//  FETCH : IR<={opcode,rt,rs,aux} on clock edge; all strobes 0 -> DECODE.
//  DECODE: rt_addr/rs_addr valid from IR. HALT -> HALT. NOP -> pc_we=1, pc_next=pc+1 -> FETCH.
//          Others -> EXEC.
//  EXEC  : ALU ops/LI: alu_op, alu_src_imm valid -> WB.
//          BEQZ: pc_we=1, pc_next = rs_zero ? pc+sext(aux) : pc+1 -> FETCH.
//  WB    : rf_we=1, pc_we=1, pc_next=pc+1 -> FETCH.
//  HALT  : all strobes 0, halted=1; exit only by reset.
//  Latency: NOP 2 cycles, BEQZ 3, ALU/LI 4 (FETCH..WB). Strobes are 1-cycle, decoded from state+IR.
//  Arithmetic: pc_next mod 2^PC_W (0xFF+1=0x00; 0x01+sext(3'b110)=0xFF). sext(aux) = {{PC_W-3{aux[2]}},aux}.
//  alu_op = IR.opcode[1:0] for ALU ops, 00 for LI (ADD with imm, rt operand forced by RF: B only).
//   LI uses alu_src_imm=1. alu_op/alu_src_imm are 0 outside EXEC/WB.
//  retired: +1 in every cycle where pc_we=1, and +1 on the DECODE->HALT transition.
//   Wraps at 2^RET_W.
//  Reset values: state FETCH, IR 0, rf_we 0, pc_we 0, pc_next 0, alu_op 0, alu_src_imm 0,
//   imm 0, halted 0, retired 0.
//  Reset mid-instruction: immediate return to FETCH; rf_we/pc_we drop asynchronously;
//   no partial writeback.
//  Instruction inputs are sampled only in FETCH; changes elsewhere are ignored.
// CONFIGURATION
//  CTRL_SINGLE_STEP_EN defined: step port exists; FETCH holds (IR not loaded) until step=1
//   is sampled. One step pulse runs exactly one instruction; a step held high runs continuously.
//   step is ignored outside FETCH.
//  Undefined: no step port; FETCH always advances next cycle.
// TESTING
//  1 Reset: rst_n=0 mid-WB of ADD -> rf_we=0 same cycle, retired=0, state FETCH after release.
//  2 LI r1,5 (8'b100_1_0_101) at pc=0x10 -> WB cycle rf_we=1, rt_addr=1, imm=0x05,
//    alu_src_imm=1, pc_next=0x11; 4 cycles; retired +1.
//  3 SUB r0,r1 (001_0_1_000) -> EXEC alu_op=01, WB rf_we=1, rt_addr=0, rs_addr=1.
//  4 BEQZ rs=1, aux=3'b110 at pc=0x01: rs_zero=1 -> pc_next=0xFF; rs_zero=0 -> pc_next=0x02;
//    rf_we never 1.
//  5 NOP at pc=0xFF -> pc_we in DECODE, pc_next=0x00 (wrap); HALT (111_x_x_xxx) -> halted=1,
//    no strobes for 20 cycles, retired +1 once.
//  6 CTRL_SINGLE_STEP_EN: step=0 for 10 cycles -> no IR load, retired constant;
//    one 1-cycle step -> exactly one instruction retires.

Source files
------------

// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl: multi-cycle control/decode stage sitting after the
// instruction memory. Latches an 8-bit instruction {opcode,rt,rs,aux}, walks
// FETCH -> DECODE -> EXEC -> WB (or HALT), drives register-file / ALU /
// program-counter controls and counts retired instructions.
//
// Optional feature: define CTRL_SINGLE_STEP_EN to add the `step` input. FETCH
// then waits for step=1 before loading the instruction register.
module instr_decode_ctrl #(
    parameter int PC_W  = 8,
    parameter int RET_W = 16
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic [2:0]       opcode,
    input  logic             rt,
    input  logic             rs,
    input  logic [2:0]       aux,
    input  logic [PC_W-1:0]  pc,
    input  logic             rs_zero,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             rt_addr,
    output logic             rs_addr,
    output logic [1:0]       alu_op,
    output logic             alu_src_imm,
    output logic [7:0]       imm,
    output logic             rf_we,
    output logic             pc_we,
    output logic [PC_W-1:0]  pc_next,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [2:0] OP_LI   = 3'b100;
    localparam logic [2:0] OP_BEQZ = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t             state_q, state_d;
    logic [7:0]         ir_q, ir_d;
    logic               halted_q, halted_d;
    logic [RET_W-1:0]   retired_q, retired_d;

    logic [2:0]         ir_op;
    logic [2:0]         ir_aux;
    logic               fetch_go;
    logic               is_alu;
    logic               in_exwb;
    logic               halt_enter;
    logic [PC_W-1:0]    br_off;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_br;

    assign ir_op  = ir_q[7:5];
    assign ir_aux = ir_q[2:0];

`ifdef CTRL_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // Next-state and instruction-register load; inputs are only captured in FETCH.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_go) begin
                    ir_d    = {opcode, rt, rs, aux};
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_op == OP_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (ir_op == OP_NOP) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = (ir_op == OP_BEQZ) ? S_FETCH : S_WB;
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes and ALU controls are decoded from state and IR so reset clears them at once.
    always_comb begin
        is_alu      = (ir_op[2] == 1'b0);
        in_exwb     = (state_q == S_EXEC) || (state_q == S_WB);
        halt_enter  = (state_q == S_DECODE) && (ir_op == OP_HALT);
        br_off      = {{(PC_W-3){ir_aux[2]}}, ir_aux};
        pc_inc      = pc + PC_W'(1);
        pc_br       = pc + br_off;

        rf_we       = (state_q == S_WB);
        pc_we       = ((state_q == S_DECODE) && (ir_op == OP_NOP)) ||
                      ((state_q == S_EXEC) && (ir_op == OP_BEQZ)) ||
                      (state_q == S_WB);
        pc_next     = '0;
        if (pc_we) begin
            pc_next = ((state_q == S_EXEC) && rs_zero) ? pc_br : pc_inc;
        end
        // LI reuses the ADD path with the immediate on operand B.
        alu_op      = (in_exwb && is_alu) ? ir_op[1:0] : 2'b00;
        alu_src_imm = in_exwb && (ir_op == OP_LI);

        retired_d   = retired_q + RET_W'(pc_we) + RET_W'(halt_enter);
    end

    assign rt_addr = ir_q[4];
    assign rs_addr = ir_q[3];
    assign imm     = {5'b00000, ir_aux};
    assign halted  = halted_q;
    assign retired = retired_q;

    // Control state, instruction register, halt flag and retired counter.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Testbench for instr_decode_ctrl: vector table, hand sequences for reset,
// halt and single-step, then randomized instructions against a reference model.
module tb_instr_decode_ctrl;

    logic        sysclk;
    logic        rst_n;
    logic [2:0]  opcode;
    logic        rt;
    logic        rs;
    logic [2:0]  aux;
    logic [7:0]  pc;
    logic        rs_zero;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step;
`endif
    logic        rt_addr;
    logic        rs_addr;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic [7:0]  imm;
    logic        rf_we;
    logic        pc_we;
    logic [7:0]  pc_next;
    logic        halted;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    instr_decode_ctrl #(.PC_W(8), .RET_W(16)) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .rt          (rt),
        .rs          (rs),
        .aux         (aux),
        .pc          (pc),
        .rs_zero     (rs_zero),
`ifdef CTRL_SINGLE_STEP_EN
        .step        (step),
`endif
        .rt_addr     (rt_addr),
        .rs_addr     (rs_addr),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .pc_next     (pc_next),
        .halted      (halted),
        .retired     (retired)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] op;
        logic       rt;
        logic       rs;
        logic [2:0] aux;
        logic [7:0] pc;
        logic       rz;
        int         e_cyc;
        logic [7:0] e_pcn;
        int         e_rf;
        logic [1:0] e_aop;
        logic       e_src;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one instruction at the start of FETCH and observe it to completion.
    task automatic run_instr(input logic [2:0] op, input logic rti, input logic rsi,
                             input logic [2:0] auxi, input logic [7:0] pci, input logic rz,
                             output int cyc, output logic [7:0] pcn, output int nrf,
                             output logic [1:0] aop, output logic [1:0] exaop,
                             output logic src, output logic rta, output logic rsa,
                             output logic [7:0] immv, output int dret, output int fetch_bad);
        logic [15:0] r0;
        bit done;
        opcode = op; rt = rti; rs = rsi; aux = auxi; pc = pci; rs_zero = rz;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b1;
`endif
        r0 = retired;
        cyc = 0; done = 0; nrf = 0; fetch_bad = 0;
        pcn = '0; aop = '0; exaop = '0; src = 1'b0; rta = 1'b0; rsa = 1'b0; immv = '0;
        while (!done && cyc < 8) begin
            @(negedge sysclk);
            cyc++;
            if (rf_we) nrf++;
            if (cyc == 1 && (rf_we || pc_we || alu_src_imm || alu_op != 2'b00)) fetch_bad = 1;
            if (cyc == 3) exaop = alu_op;
            if (pc_we) begin
                pcn = pc_next; aop = alu_op; src = alu_src_imm;
                rta = rt_addr; rsa = rs_addr; immv = imm; done = 1;
            end
            @(posedge sysclk); #1;
            if (cyc == 1) begin
`ifdef CTRL_SINGLE_STEP_EN
                step = 1'b0;
`endif
                opcode = 3'($urandom); rt = 1'($urandom); rs = 1'($urandom); aux = 3'($urandom);
            end
        end
        if (!done) cyc = 99;
        dret = int'(16'(retired - r0));
    endtask

    // Reference behaviour derived from the instruction set definition.
    function automatic void model(input logic [2:0] op, input logic [7:0] pci, input logic rz,
                                  input logic [2:0] auxi, output int cyc, output logic [7:0] pcn,
                                  output int nrf, output logic [1:0] aop, output logic src);
        int off;
        int target;
        cyc = 4; nrf = 1; aop = 2'b00; src = 1'b0;
        target = int'(pci) + 1;
        case (op)
            3'd0: aop = 2'd0;
            3'd1: aop = 2'd1;
            3'd2: aop = 2'd2;
            3'd3: aop = 2'd3;
            3'd4: src = 1'b1;
            3'd5: begin
                cyc = 3; nrf = 0;
                off = (auxi >= 3'd4) ? int'(auxi) - 8 : int'(auxi);
                if (rz) target = int'(pci) + off;
            end
            default: begin cyc = 2; nrf = 0; end
        endcase
        pcn = 8'((target + 256) % 256);
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        @(posedge sysclk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc, nrf, dret, fbad;
        logic [7:0] pcn, immv;
        logic [1:0] aop, exaop;
        logic src, rta, rsa;
        int e_cyc, e_nrf, cnt;
        logic [7:0] e_pcn;
        logic [1:0] e_aop;
        logic e_src;
        logic [15:0] r0;

        vecs[0]  = '{3'd4, 1'b1, 1'b0, 3'd5, 8'h10, 1'b0, 4, 8'h11, 1, 2'd0, 1'b1};
        vecs[1]  = '{3'd1, 1'b0, 1'b1, 3'd0, 8'h20, 1'b0, 4, 8'h21, 1, 2'd1, 1'b0};
        vecs[2]  = '{3'd5, 1'b0, 1'b1, 3'd6, 8'h01, 1'b1, 3, 8'hFF, 0, 2'd0, 1'b0};
        vecs[3]  = '{3'd5, 1'b0, 1'b1, 3'd6, 8'h01, 1'b0, 3, 8'h02, 0, 2'd0, 1'b0};
        vecs[4]  = '{3'd6, 1'b1, 1'b1, 3'd2, 8'hFF, 1'b0, 2, 8'h00, 0, 2'd0, 1'b0};
        vecs[5]  = '{3'd0, 1'b1, 1'b1, 3'd0, 8'h7F, 1'b0, 4, 8'h80, 1, 2'd0, 1'b0};
        vecs[6]  = '{3'd2, 1'b0, 1'b0, 3'd7, 8'h33, 1'b1, 4, 8'h34, 1, 2'd2, 1'b0};
        vecs[7]  = '{3'd3, 1'b1, 1'b0, 3'd1, 8'hFF, 1'b0, 4, 8'h00, 1, 2'd3, 1'b0};
        vecs[8]  = '{3'd5, 1'b1, 1'b0, 3'd3, 8'hFE, 1'b1, 3, 8'h01, 0, 2'd0, 1'b0};
        vecs[9]  = '{3'd5, 1'b0, 1'b0, 3'd4, 8'h02, 1'b1, 3, 8'hFE, 0, 2'd0, 1'b0};
        vecs[10] = '{3'd4, 1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 4, 8'h01, 1, 2'd0, 1'b1};

        opcode = 3'd0; rt = 1'b0; rs = 1'b0; aux = 3'd0; pc = 8'h00; rs_zero = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0;
`endif
        rst_n = 1'b0;
        #3;
        chk("reset_retired", retired, 0);
        chk("reset_halted", halted, 0);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_pc_we", pc_we, 0);
        chk("reset_pc_next", pc_next, 0);
        chk("reset_alu_op", alu_op, 0);
        chk("reset_alu_src_imm", alu_src_imm, 0);
        chk("reset_imm", imm, 0);
        @(posedge sysclk); #1;
        rst_n = 1'b1;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].rt, vecs[i].rs, vecs[i].aux, vecs[i].pc, vecs[i].rz,
                      cyc, pcn, nrf, aop, exaop, src, rta, rsa, immv, dret, fbad);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].e_cyc);
            chk($sformatf("vec%0d_pc_next", i), pcn, vecs[i].e_pcn);
            chk($sformatf("vec%0d_rf_we_count", i), nrf, vecs[i].e_rf);
            chk($sformatf("vec%0d_alu_op", i), aop, vecs[i].e_aop);
            chk($sformatf("vec%0d_alu_src_imm", i), src, vecs[i].e_src);
            if (vecs[i].e_cyc == 4) chk($sformatf("vec%0d_exec_alu_op", i), exaop, vecs[i].e_aop);
            chk($sformatf("vec%0d_rt_addr", i), rta, vecs[i].rt);
            chk($sformatf("vec%0d_rs_addr", i), rsa, vecs[i].rs);
            chk($sformatf("vec%0d_imm", i), immv, {5'b0, vecs[i].aux});
            chk($sformatf("vec%0d_retired_delta", i), dret, 1);
            chk($sformatf("vec%0d_fetch_strobes", i), fbad, 0);
        end

        // Reset asserted during WB of an ADD.
        opcode = 3'd0; rt = 1'b1; rs = 1'b0; aux = 3'd0; pc = 8'h40; rs_zero = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b1;
`endif
        for (int c = 1; c <= 3; c++) begin
            @(posedge sysclk); #1;
`ifdef CTRL_SINGLE_STEP_EN
            step = 1'b0;
`endif
        end
        @(negedge sysclk);
        chk("midwb_rf_we_before_reset", rf_we, 1);
        rst_n = 1'b0;
        #1;
        chk("midwb_rf_we_async_drop", rf_we, 0);
        chk("midwb_pc_we_async_drop", pc_we, 0);
        chk("midwb_retired_cleared", retired, 0);
        @(posedge sysclk); #1;
        rst_n = 1'b1;
        run_instr(3'd6, 1'b0, 1'b0, 3'd0, 8'h05, 1'b0,
                  cyc, pcn, nrf, aop, exaop, src, rta, rsa, immv, dret, fbad);
        chk("post_reset_nop_cycles", cyc, 2);
        chk("post_reset_nop_pc_next", pcn, 8'h06);
        chk("post_reset_retired", retired, 1);

        // HALT: retires once, then stays quiet until reset.
        r0 = retired;
        opcode = 3'd7; rt = 1'b1; rs = 1'b1; aux = 3'd7; pc = 8'h50;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b1;
`endif
        @(posedge sysclk); #1;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0;
`endif
        @(negedge sysclk);
        chk("halt_decode_pc_we", pc_we, 0);
        @(posedge sysclk); #1;
        chk("halt_halted", halted, 1);
        chk("halt_retired_once", int'(16'(retired - r0)), 1);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sysclk);
            if (rf_we || pc_we || alu_src_imm || alu_op != 2'b00 || !halted) cnt++;
        end
        chk("halt_quiet_20_cycles", cnt, 0);
        chk("halt_retired_stable", int'(16'(retired - r0)), 1);
        pulse_reset();
        chk("halt_cleared_by_reset", halted, 0);

`ifdef CTRL_SINGLE_STEP_EN
        // Single-step: FETCH holds without step, one pulse runs one instruction.
        r0 = retired;
        opcode = 3'd6; rt = 1'b0; rs = 1'b0; aux = 3'd0; pc = 8'h60; step = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sysclk);
            if (pc_we) cnt++;
        end
        chk("step_hold_pc_we", cnt, 0);
        chk("step_hold_retired", int'(16'(retired - r0)), 0);
        @(posedge sysclk); #1;
        step = 1'b1;
        @(posedge sysclk); #1;
        step = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sysclk);
            if (pc_we) cnt++;
        end
        chk("step_pulse_pc_we", cnt, 1);
        chk("step_pulse_retired", int'(16'(retired - r0)), 1);
`endif

        // Randomized instructions (HALT excluded) against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [2:0] rop, raux;
            logic [7:0] rpc;
            logic rrt, rrs, rrz;
            rop  = 3'($urandom_range(0, 6));
            raux = 3'($urandom);
            rpc  = 8'($urandom);
            rrt  = 1'($urandom);
            rrs  = 1'($urandom);
            rrz  = 1'($urandom);
            model(rop, rpc, rrz, raux, e_cyc, e_pcn, e_nrf, e_aop, e_src);
            run_instr(rop, rrt, rrs, raux, rpc, rrz,
                      cyc, pcn, nrf, aop, exaop, src, rta, rsa, immv, dret, fbad);
            chk($sformatf("rnd%0d_op%0d_cycles", n, rop), cyc, e_cyc);
            chk($sformatf("rnd%0d_op%0d_pc_next", n, rop), pcn, e_pcn);
            chk($sformatf("rnd%0d_op%0d_rf_we", n, rop), nrf, e_nrf);
            chk($sformatf("rnd%0d_op%0d_alu_op", n, rop), aop, e_aop);
            chk($sformatf("rnd%0d_op%0d_alu_src_imm", n, rop), src, e_src);
            chk($sformatf("rnd%0d_op%0d_fields", n, rop), {rta, rsa, immv}, {rrt, rrs, 5'b0, raux});
            chk($sformatf("rnd%0d_op%0d_retired", n, rop), dret, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
